// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared types for the countdown timer
package countdown_timer_pkg;

   // Controller states: idle (halted), counting, and paused with prescaler phase held
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } timer_state_t;

   // Width of a counter that must hold 0..modulus-1, never narrower than one bit
   function automatic int phase_width(input int modulus);
      if (modulus > 1)
         return $clog2(modulus);
      else
         return 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the clock into one tick every PRESCALE enabled cycles
module tick_prescaler
   import countdown_timer_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int W = phase_width(PRESCALE);
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] phase;

   // The tick is only meaningful while counting, so it is qualified by enable;
   // a disabled prescaler never ticks and keeps its phase for a later resume.
   assign tick = enable && (phase == LAST);

   // Phase counter: clear wins over enable, wraps explicitly at PRESCALE-1
   always_ff @(posedge clock) begin
      if (reset) begin
         phase <= '0;
      end else if (clear) begin
         phase <= '0;
      end else if (enable) begin
         if (phase == LAST)
            phase <= '0;
         else
            phase <= phase + W'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with pause, expiry pulse and auto-reload
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int N        = 8,
   parameter int PRESCALE = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] load_value,
   input  logic         start,
   input  logic         stop,
   input  logic         auto_reload,
   output logic [N-1:0] count,
   output logic         running,
   output logic         done
);

   timer_state_t state;
   timer_state_t state_next;

   logic [N-1:0] reload_reg;
   logic [N-1:0] reload_next;
   logic [N-1:0] count_next;
   logic         done_next;

   logic presc_enable;
   logic presc_clear;
   logic tick;
   logic start_ok;
   logic expire;
   logic do_reload;

   // The prescaler only advances while running and not being stopped or
   // loaded this cycle, so a stop freezes the phase exactly where it was.
   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .enable (presc_enable),
      .clear  (presc_clear),
      .tick   (tick)
   );

   // Command qualification in priority order load > stop > start
   always_comb begin
      start_ok     = 1'b0;
      presc_enable = 1'b0;
      presc_clear  = 1'b0;
      expire       = 1'b0;
      do_reload    = 1'b0;

      // A fresh start from idle needs a non-zero count; resume from pause does not clear
      start_ok     = (state == IDLE) && start && !stop && !load && (count != '0);
      presc_enable = (state == RUN) && !stop && !load;
      presc_clear  = load || start_ok;
      expire       = tick && (count == N'(1));
      // auto_reload is only looked at here, at the expiry tick
      do_reload    = auto_reload && (reload_reg != '0);
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (load) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok)
                  state_next = RUN;
            end
            RUN: begin
               if (stop)
                  state_next = PAUSE;
               else if (expire && !do_reload)
                  state_next = IDLE;
            end
            PAUSE: begin
               if (!stop && start)
                  state_next = RUN;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Output/datapath next values: count, reload register and expiry pulse
   always_comb begin
      count_next  = count;
      reload_next = reload_reg;
      done_next   = 1'b0;

      if (load) begin
         count_next  = load_value;
         reload_next = load_value;
      end else if (tick) begin
         if (count > N'(1)) begin
            count_next = count - N'(1);
         end else if (count == N'(1)) begin
            done_next  = 1'b1;
            count_next = do_reload ? reload_reg : '0;
         end
         // a tick at zero holds zero: the count never wraps
      end
   end

   // Registered outputs and reload register
   always_ff @(posedge clock) begin
      if (reset) begin
         count      <= '0;
         reload_reg <= '0;
         done       <= 1'b0;
         running    <= 1'b0;
      end else begin
         count      <= count_next;
         reload_reg <= reload_next;
         done       <= done_next;
         running    <= (state_next == RUN);
      end
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable N-bit down-counter and timer, the counterpart of the team's free-running up-counter. It is loaded with a value and started. It then decrements once every PRESCALE clock cycles and raises a one-cycle `done` pulse when it reaches zero. It can pause and resume, and can optionally auto-reload for periodic operation. It sits beside the display/stopwatch logic on the lab board and drives timeouts, blink rates and countdown displays.

## Interface
Parameters:
- `N`, 8, counter width in bits (≥ 2).
- `PRESCALE`, 4, clock cycles per decrement tick (≥ 1).

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `load`  in  1  load `load_value` into counter and reload register.
- `load_value`  in  N  value to load.
- `start`  in  1  begin or resume counting.
- `stop`  in  1  pause counting.
- `auto_reload`  in  1  on expiry, reload and keep running instead of halting.
- `count`  out  N  current count (registered).
- `running`  out  1  high while in RUN (registered).
- `done`  out  1  one-cycle pulse on expiry (registered).

## Operation
- The controller has three states: IDLE, RUN and PAUSE.
- Reset values: all outputs are 0, the reload register is 0, the prescaler is 0, and the state is IDLE.
- Input priority per cycle is reset > load > stop > start.
- `load` (any state):
  - `count` and the reload register take `load_value`.
  - The prescaler clears, the state goes to IDLE, and no `done` is issued.
- IDLE + `start`:
  - If `count` ≠ 0, the state goes to RUN and the prescaler clears.
  - If `count` = 0, `start` is ignored.
- RUN + `stop`: the state goes to PAUSE. The prescaler value and `count` are held.
- PAUSE + `start`: the state goes to RUN and the prescaler resumes from its held value, so no time is lost or gained.
- `stop` in IDLE or PAUSE, and `start` in RUN, are ignored.
- RUN, prescaler:
  - The prescaler counts 0..PRESCALE-1.
  - A tick occurs in the cycle where prescaler = PRESCALE-1, and the prescaler then wraps to 0.
  - PRESCALE = 1 gives a tick every cycle.
- Tick with `count` > 1: `count` ← `count` − 1.
- Tick with `count` = 1 (expiry): `done` is 1 for the next cycle. Then:
  - If `auto_reload` = 1 and the reload register ≠ 0, `count` ← reload register and the state stays RUN.
  - Otherwise `count` ← 0 and the state goes to IDLE.
- `auto_reload` is sampled only at the expiry tick.
- `count` never wraps below 0. Arithmetic is unsigned N-bit.
- Reset mid-run overrides everything. No `done` pulse is generated.

## Timing
- Decisions take effect at the rising edge that samples the inputs. Outputs are visible the following cycle.
- Start timing: `start` is sampled at edge k, and `running` = 1 from edge k.
  - The first decrement occurs at edge k+PRESCALE.
  - With loaded value L, expiry occurs at edge k+L·PRESCALE: `done` = 1 for exactly one cycle and `count` = 0 (or L on reload).
- `stop` at edge p freezes `count` from edge p. A decrement scheduled for edge p does not happen.
- Auto-reload period is L·PRESCALE cycles, with consecutive `done` pulses exactly that far apart.
- `load` at edge j: `count` = `load_value` and `running` = 0 from edge j.

## Structure
- Package `countdown_timer_pkg`:
  - `timer_state_t` enum (IDLE, RUN, PAUSE).
- Sub-module `tick_prescaler`:
  - Parameter PRESCALE; inputs `clock`, `reset`, `enable`, `clear`; output `tick`.
  - Counter width is $clog2(PRESCALE) bits, with a minimum of 1.
  - Holds its value when `enable` = 0.
- The top level holds the FSM, the count register and the reload register.

## Test plan
- **Reset:** assert `reset` 2 cycles from arbitrary state → `count` = 0, `running` = 0, `done` = 0; `start` alone then ignored since `count` = 0.
- **One-shot:** N=8, PRESCALE=4, load 5, start at edge k → `count` 5,4,3,2,1 stepping every 4 cycles; `done` high only at cycle k+20; then `count` = 0 and `running` = 0.
- **Auto-reload:** auto_reload=1, load 3 → `count` sequence 3,2,1,3,2,1…; `done` pulses 12 cycles apart, `running` stays 1.
- **Pause/resume:** stop when `count` = 3 with prescaler mid-period, hold 10 cycles, start → `count` stays 3 throughout the pause; expiry delayed by exactly the pause duration.
- **Load abort:** load 200 while running at `count` = 7 → `count` = 200, `running` = 0, no `done`.
- **Reset and PRESCALE=1:** reset mid-run → zeros next cycle, no `done`. PRESCALE=1, load 2, start at edge k → `done` at k+2.
